// File: rtl/hazard_sequencer_if.sv
// Pipeline-side bundle for hazard_sequencer: ID/EX observations in, stall/flush controls out.
// Optional perf counters are present only when HAZARD_PERF_EN is defined.
interface hazard_sequencer_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] IF_ID_Rs;
    logic [REG_AW-1:0] IF_ID_Rt;
    logic              ID_UsesRt;
    logic              ID_Jump;
    logic [REG_AW-1:0] ID_EX_Rt;
    logic              ID_EX_MemRead;
    logic              EX_MulStart;
    logic              EX_BranchTaken;

    logic              PCWrite;
    logic              IFIDWrite;
    logic              Control;
    logic              IFIDFlush;
    logic              IDEXFlush;
    logic              EXFreeze;
    logic              Busy;
    logic [1:0]        DbgState;
`ifdef HAZARD_PERF_EN
    logic [31:0]       StallCycles;
    logic [15:0]       FlushCount;
`endif

    // No valid/ready handshake here: every signal is a per-cycle level, and the
    // control outputs are valid combinationally in the same cycle as the inputs.
    modport master (
`ifdef HAZARD_PERF_EN
        input  StallCycles,
        input  FlushCount,
`endif
        output IF_ID_Rs, IF_ID_Rt, ID_UsesRt, ID_Jump,
        output ID_EX_Rt, ID_EX_MemRead, EX_MulStart, EX_BranchTaken,
        input  PCWrite, IFIDWrite, Control, IFIDFlush, IDEXFlush,
        input  EXFreeze, Busy, DbgState
    );

    modport slave (
`ifdef HAZARD_PERF_EN
        output StallCycles,
        output FlushCount,
`endif
        input  IF_ID_Rs, IF_ID_Rt, ID_UsesRt, ID_Jump,
        input  ID_EX_Rt, ID_EX_MemRead, EX_MulStart, EX_BranchTaken,
        output PCWrite, IFIDWrite, Control, IFIDFlush, IDEXFlush,
        output EXFreeze, Busy, DbgState
    );
endinterface

// File: rtl/hazard_sequencer.sv
// Load-use / branch / jump / multi-cycle-op stall sequencer for the 5-stage MIPS pipeline.
// Define HAZARD_PERF_EN to build the saturating StallCycles/FlushCount counters.
module hazard_sequencer #(
    parameter int MUL_LAT = 4,
    parameter int REG_AW  = 5
) (
    input  logic              Clk,
    input  logic              Rst,
    hazard_sequencer_if.slave hz
);
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LOADUSE = 2'd1,
        MULBUSY = 2'd2
    } state_t;

    localparam logic [REG_AW-1:0] ZERO_REG = '0;
    localparam logic [3:0]        CNT_LOAD = 4'(MUL_LAT - 2);

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_cnt;
    logic [3:0] w_next_cnt;

    logic w_lu;
    logic w_pc_write;
    logic w_ifid_write;
    logic w_control;
    logic w_ifid_flush;
    logic w_idex_flush;
    logic w_ex_freeze;
    logic w_busy;

    assign w_lu = hz.ID_EX_MemRead && (hz.ID_EX_Rt != ZERO_REG) &&
                  ((hz.ID_EX_Rt == hz.IF_ID_Rs) ||
                   (hz.ID_UsesRt && (hz.ID_EX_Rt == hz.IF_ID_Rt)));

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_pc_write   = 1'b1;
        w_ifid_write = 1'b1;
        w_control    = 1'b1;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        w_ex_freeze  = 1'b0;
        w_busy       = 1'b0;
        // Gating on Rst keeps outputs at their idle values while reset is held,
        // whatever the pipeline inputs are doing.
        if (Rst) begin
            unique case (r_state)
                RUN: begin
                    if (hz.EX_BranchTaken) begin
                        w_ifid_flush = 1'b1;
                        w_idex_flush = 1'b1;
                        w_control    = 1'b0;
                    end else if (hz.EX_MulStart) begin
                        w_pc_write   = 1'b0;
                        w_ifid_write = 1'b0;
                        w_ex_freeze  = 1'b1;
                        w_busy       = 1'b1;
                        w_next_cnt   = CNT_LOAD;
                        w_next_state = MULBUSY;
                    end else if (w_lu) begin
                        w_pc_write   = 1'b0;
                        w_ifid_write = 1'b0;
                        w_control    = 1'b0;
                        w_next_state = LOADUSE;
                    end else if (hz.ID_Jump) begin
                        w_ifid_flush = 1'b1;
                    end
                end
                LOADUSE: begin
                    w_next_state = RUN;
                    if (hz.EX_BranchTaken) begin
                        w_ifid_flush = 1'b1;
                        w_idex_flush = 1'b1;
                        w_control    = 1'b0;
                    end
                end
                MULBUSY: begin
                    w_pc_write   = 1'b0;
                    w_ifid_write = 1'b0;
                    w_ex_freeze  = 1'b1;
                    w_busy       = 1'b1;
                    if (r_cnt == 4'd0) begin
                        w_next_state = RUN;
                    end else begin
                        w_next_cnt = r_cnt - 4'd1;
                    end
                end
                default: begin
                    w_next_state = RUN;
                    w_next_cnt   = 4'd0;
                end
            endcase
        end
    end

    assign hz.PCWrite   = w_pc_write;
    assign hz.IFIDWrite = w_ifid_write;
    assign hz.Control   = w_control;
    assign hz.IFIDFlush = w_ifid_flush;
    assign hz.IDEXFlush = w_idex_flush;
    assign hz.EXFreeze  = w_ex_freeze;
    assign hz.Busy      = w_busy;
    assign hz.DbgState  = r_state;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [15:0] r_flush_count;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 16'd0;
        end else begin
            if (!w_pc_write && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_ifid_flush && (r_flush_count != 16'hFFFF)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign hz.StallCycles = r_stall_cycles;
    assign hz.FlushCount  = r_flush_count;
`endif
endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: two instances (MUL_LAT=4 and MUL_LAT=2) share
// stimulus; expected {state, outputs} words are queued per step and popped at the sample point.
module tb_hazard_sequencer;
    logic Clk = 1'b0;
    logic Rst;

    always #5 Clk = ~Clk;

    hazard_sequencer_if #(.REG_AW(5)) if_a ();
    hazard_sequencer_if #(.REG_AW(5)) if_b ();

    hazard_sequencer #(.MUL_LAT(4), .REG_AW(5)) dut_a (
        .Clk (Clk),
        .Rst (Rst),
        .hz  (if_a.slave)
    );

    hazard_sequencer #(.MUL_LAT(2), .REG_AW(5)) dut_b (
        .Clk (Clk),
        .Rst (Rst),
        .hz  (if_b.slave)
    );

    localparam logic [1:0] S_RUN = 2'd0;
    localparam logic [1:0] S_LU  = 2'd1;
    localparam logic [1:0] S_MB  = 2'd2;

    // {PCWrite, IFIDWrite, Control, IFIDFlush, IDEXFlush, EXFreeze, Busy}
    localparam logic [6:0] O_RST = 7'b1110000;
    localparam logic [6:0] O_LU  = 7'b0000000;
    localparam logic [6:0] O_BR  = 7'b1101100;
    localparam logic [6:0] O_MUL = 7'b0010011;
    localparam logic [6:0] O_JMP = 7'b1111000;

    logic [8:0] obs_a;
    logic [8:0] obs_b;
    assign obs_a = {if_a.DbgState, if_a.PCWrite, if_a.IFIDWrite, if_a.Control,
                    if_a.IFIDFlush, if_a.IDEXFlush, if_a.EXFreeze, if_a.Busy};
    assign obs_b = {if_b.DbgState, if_b.PCWrite, if_b.IFIDWrite, if_b.Control,
                    if_b.IFIDFlush, if_b.IDEXFlush, if_b.EXFreeze, if_b.Busy};

    logic [8:0] exp_a_q[$];
    logic [8:0] exp_b_q[$];
    string      tag_q[$];

    int checks = 0;
    int errors = 0;

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                         input logic jump, input logic [4:0] ex_rt, input logic memread,
                         input logic mulstart, input logic branch);
        if_a.IF_ID_Rs       = rs;       if_b.IF_ID_Rs       = rs;
        if_a.IF_ID_Rt       = rt;       if_b.IF_ID_Rt       = rt;
        if_a.ID_UsesRt      = uses_rt;  if_b.ID_UsesRt      = uses_rt;
        if_a.ID_Jump        = jump;     if_b.ID_Jump        = jump;
        if_a.ID_EX_Rt       = ex_rt;    if_b.ID_EX_Rt       = ex_rt;
        if_a.ID_EX_MemRead  = memread;  if_b.ID_EX_MemRead  = memread;
        if_a.EX_MulStart    = mulstart; if_b.EX_MulStart    = mulstart;
        if_a.EX_BranchTaken = branch;   if_b.EX_BranchTaken = branch;
    endtask

    task automatic push_exp(input logic [8:0] ea, input logic [8:0] eb, input string tag);
        exp_a_q.push_back(ea);
        exp_b_q.push_back(eb);
        tag_q.push_back(tag);
    endtask

    task automatic compare_pop();
        logic [8:0] ea;
        logic [8:0] eb;
        string      t;
        ea = exp_a_q.pop_front();
        eb = exp_b_q.pop_front();
        t  = tag_q.pop_front();
        checks++;
        assert (obs_a === ea) else begin
            errors++;
            $error("FAIL %s lat4 observed=%b expected=%b", t, obs_a, ea);
        end
        checks++;
        assert (obs_b === eb) else begin
            errors++;
            $error("FAIL %s lat2 observed=%b expected=%b", t, obs_b, eb);
        end
    endtask

    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                        input logic jump, input logic [4:0] ex_rt, input logic memread,
                        input logic mulstart, input logic branch,
                        input logic [8:0] ea, input logic [8:0] eb, input string tag);
        @(posedge Clk);
        #1;
        drive(rs, rt, uses_rt, jump, ex_rt, memread, mulstart, branch);
        push_exp(ea, eb, tag);
        @(negedge Clk);
        compare_pop();
    endtask

    task automatic idle(input logic [8:0] ea, input logic [8:0] eb, input string tag);
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ea, eb, tag);
    endtask

`ifdef HAZARD_PERF_EN
    task automatic check_perf_zero(input string tag);
        checks++;
        assert ((if_a.StallCycles === 32'd0) && (if_a.FlushCount === 16'd0)) else begin
            errors++;
            $error("FAIL %s perf observed=%0d/%0d expected=0/0", tag,
                   if_a.StallCycles, if_a.FlushCount);
        end
    endtask
`endif

    initial begin
        Rst = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #2;
        push_exp({S_RUN, O_RST}, {S_RUN, O_RST}, "reset");
        compare_pop();
`ifdef HAZARD_PERF_EN
        check_perf_zero("reset");
`endif
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1;

        idle({S_RUN, O_RST}, {S_RUN, O_RST}, "idle");

        // load-use on rs, held inputs in LOADUSE must not re-stall
        step(5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, {S_RUN, O_LU}, {S_RUN, O_LU}, "lu_rs");
        step(5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, {S_LU, O_RST}, {S_LU, O_RST}, "lu_rs_bubble");
        idle({S_RUN, O_RST}, {S_RUN, O_RST}, "lu_rs_after");

        step(5'd3, 5'd12, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, {S_RUN, O_LU}, {S_RUN, O_LU}, "lu_rt");
        idle({S_LU, O_RST}, {S_LU, O_RST}, "lu_rt_bubble");
        idle({S_RUN, O_RST}, {S_RUN, O_RST}, "lu_rt_after");

        step(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, {S_RUN, O_RST}, {S_RUN, O_RST}, "lu_r0");
        step(5'd4, 5'd9, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, {S_RUN, O_RST}, {S_RUN, O_RST}, "rt_unused");
        step(5'd8, 5'd8, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, {S_RUN, O_RST}, {S_RUN, O_RST}, "no_load");

        // branch wins over lu and jump
        step(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, {S_RUN, O_BR}, {S_RUN, O_BR}, "br_over_lu");
        idle({S_RUN, O_RST}, {S_RUN, O_RST}, "br_after");

        step(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, {S_RUN, O_JMP}, {S_RUN, O_JMP}, "jump");
        idle({S_RUN, O_RST}, {S_RUN, O_RST}, "jump_after");

        // multiply with concurrent lu; branch/mulstart ignored while busy
        step(5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, {S_RUN, O_MUL}, {S_RUN, O_MUL}, "mul_start");
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, {S_MB, O_MUL}, {S_MB, O_MUL}, "mul_c1");
        idle({S_MB, O_MUL}, {S_RUN, O_RST}, "mul_c2");
        idle({S_MB, O_MUL}, {S_RUN, O_RST}, "mul_c3");
        step(5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, {S_RUN, O_LU}, {S_RUN, O_LU}, "mul_then_lu");
        idle({S_LU, O_RST}, {S_LU, O_RST}, "mul_lu_bubble");
        idle({S_RUN, O_RST}, {S_RUN, O_RST}, "mul_lu_after");

        // asynchronous reset in the second MULBUSY cycle
        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, {S_RUN, O_MUL}, {S_RUN, O_MUL}, "rmul_start");
        idle({S_MB, O_MUL}, {S_MB, O_MUL}, "rmul_c1");
        @(posedge Clk);
        #1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        push_exp({S_MB, O_MUL}, {S_RUN, O_RST}, "rmul_c2");
        compare_pop();
        #1;
        Rst = 1'b0;
        #1;
        push_exp({S_RUN, O_RST}, {S_RUN, O_RST}, "rmul_async");
        compare_pop();
`ifdef HAZARD_PERF_EN
        check_perf_zero("rmul_async");
`endif
        @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1;

        step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, {S_RUN, O_MUL}, {S_RUN, O_MUL}, "mul2_start");
        idle({S_MB, O_MUL}, {S_MB, O_MUL}, "mul2_c1");
        idle({S_MB, O_MUL}, {S_RUN, O_RST}, "mul2_c2");
        idle({S_MB, O_MUL}, {S_RUN, O_RST}, "mul2_c3");
        idle({S_RUN, O_RST}, {S_RUN, O_RST}, "mul2_release");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
